// File: rtl/flex_x_counter.sv
// Programmable-rollover up-counter producing the Work Dispatcher x index.
// Counts 1..rollover_val and wraps to 1; a registered flag marks count == rollover_val.
module flex_x_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = NUM_CNT_BITS'(0);
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] count_r;
    logic                    flag_r;
    logic [NUM_CNT_BITS-1:0] next_count_s;
    logic                    next_flag_s;

    // Next-count selection: clear beats enable; the +1 is only taken below the terminal
    // count, so it cannot overflow. rollover_val of zero pins the count at zero.
    always_comb begin
        next_count_s = count_r;
        if (clear) begin
            next_count_s = CNT_ZERO;
        end else if (count_enable) begin
            if (rollover_val == CNT_ZERO) begin
                next_count_s = CNT_ZERO;
            end else if (count_r < rollover_val) begin
                next_count_s = count_r + CNT_ONE;
            end else begin
                next_count_s = CNT_ONE;
            end
        end else begin
            next_count_s = count_r;
        end
    end

    // The flag is computed from the upcoming count so it is registered alongside it.
    always_comb begin
        next_flag_s = 1'b0;
        if (next_count_s == rollover_val) begin
            next_flag_s = 1'b1;
        end else begin
            next_flag_s = 1'b0;
        end
    end

    // Count and flag registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            count_r <= CNT_ZERO;
            flag_r  <= 1'b0;
        end else begin
            count_r <= next_count_s;
            flag_r  <= next_flag_s;
        end
    end

    assign count_out     = count_r;
    assign rollover_flag = flag_r;

endmodule

// File: tb/tb_flex_x_counter.sv
// Directed self-checking bench for flex_x_counter (NUM_CNT_BITS = 4).
module tb_flex_x_counter;

    logic       clk;
    logic       n_rst;
    logic       clear;
    logic       count_enable;
    logic [3:0] rollover_val;
    logic [3:0] count_out;
    logic       rollover_flag;

    int tests_run;
    int tests_failed;

    flex_x_counter #(.NUM_CNT_BITS(4)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .count_enable (count_enable),
        .rollover_val (rollover_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge happen, then check both outputs.
    task automatic step(input logic rst, input logic clr, input logic en,
                        input logic [3:0] rv, input logic [3:0] exp_cnt,
                        input logic exp_flag, input string tag);
        n_rst        = rst;
        clear        = clr;
        count_enable = en;
        rollover_val = rv;
        @(posedge clk);
        #1;
        tests_run++;
        assert (count_out === exp_cnt) else begin
            tests_failed++;
            $error("FAIL %s count: observed %0d expected %0d", tag, count_out, exp_cnt);
        end
        tests_run++;
        assert (rollover_flag === exp_flag) else begin
            tests_failed++;
            $error("FAIL %s flag: observed %0b expected %0b", tag, rollover_flag, exp_flag);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        n_rst        = 1'b1;
        clear        = 1'b0;
        count_enable = 1'b1;
        rollover_val = 4'd4;

        // Reset held with enable high
        step(1'b1, 1'b0, 1'b1, 4'd4, 4'd0, 1'b0, "reset0");
        step(1'b1, 1'b0, 1'b1, 4'd4, 4'd0, 1'b0, "reset1");

        // Normal count to 4 and wrap
        step(1'b0, 1'b0, 1'b1, 4'd4, 4'd1, 1'b0, "cnt1");
        step(1'b0, 1'b0, 1'b1, 4'd4, 4'd2, 1'b0, "cnt2");
        step(1'b0, 1'b0, 1'b1, 4'd4, 4'd3, 1'b0, "cnt3");
        step(1'b0, 1'b0, 1'b1, 4'd4, 4'd4, 1'b1, "cnt4");
        step(1'b0, 1'b0, 1'b1, 4'd4, 4'd1, 1'b0, "wrap1");
        step(1'b0, 1'b0, 1'b1, 4'd4, 4'd2, 1'b0, "wrap2");

        // Clear beats enable, then resume from 1
        step(1'b0, 1'b1, 1'b1, 4'd4, 4'd0, 1'b0, "clr_pri");
        step(1'b0, 1'b0, 1'b1, 4'd4, 4'd1, 1'b0, "resume1");
        step(1'b0, 1'b0, 1'b1, 4'd4, 4'd2, 1'b0, "resume2");
        step(1'b0, 1'b0, 1'b1, 4'd4, 4'd3, 1'b0, "resume3");
        step(1'b0, 1'b0, 1'b1, 4'd4, 4'd4, 1'b1, "resume4");

        // Hold at terminal count, then clear
        step(1'b0, 1'b0, 1'b0, 4'd4, 4'd4, 1'b1, "hold_a");
        step(1'b0, 1'b0, 1'b0, 4'd4, 4'd4, 1'b1, "hold_b");
        step(1'b0, 1'b0, 1'b0, 4'd4, 4'd4, 1'b1, "hold_c");
        step(1'b0, 1'b1, 1'b0, 4'd4, 4'd0, 1'b0, "hold_clr");

        // Count to 6 with rollover 8, then lower rollover to 3
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 4'd8, 4'(i), 1'b0, "rv8_cnt");
        end
        step(1'b0, 1'b0, 1'b1, 4'd3, 4'd1, 1'b0, "rv_lower");
        step(1'b0, 1'b0, 1'b1, 4'd3, 4'd2, 1'b0, "rv3_cnt2");
        step(1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 1'b1, "rv3_cnt3");

        // Degenerate rollover of zero
        step(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, "rv0_clr");
        step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, "rv0_hold_a");
        step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b1, "rv0_hold_b");

        // Full-width rollover at 15 with no overflow to 0
        step(1'b0, 1'b1, 1'b0, 4'd15, 4'd0, 1'b0, "w_clr");
        for (int i = 1; i <= 15; i++) begin
            step(1'b0, 1'b0, 1'b1, 4'd15, 4'(i), (i == 15) ? 1'b1 : 1'b0, "w_cnt");
        end
        step(1'b0, 1'b0, 1'b1, 4'd15, 4'd1, 1'b0, "w_wrap");
        step(1'b0, 1'b0, 1'b1, 4'd15, 4'd2, 1'b0, "w_cnt2");

        // Reset mid-count overrides clear and enable
        step(1'b1, 1'b1, 1'b1, 4'd15, 4'd0, 1'b0, "rst_mid");
        step(1'b0, 1'b0, 1'b1, 4'd2, 4'd1, 1'b0, "post_rst1");
        step(1'b0, 1'b0, 1'b1, 4'd2, 4'd2, 1'b1, "post_rst2");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
